// File: rtl/sad_tree_min.sv
// =============================================================================
// Module      : sad_tree_min
// Description : Row adder tree, per-candidate SAD accumulator and min tracker.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module sad_tree_min #(
    parameter int PIXEL    = 8,
    parameter int NUM_PE   = 8,
    parameter int ROWS     = 8,
    parameter int NUM_CAND = 64,
    parameter int SAD_W    = PIXEL + $clog2(NUM_PE) + $clog2(ROWS),
    parameter int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    search_start,
    input  logic                    abs_valid,
    input  logic [NUM_PE*PIXEL-1:0] abs_in,
    output logic                    busy,
    output logic                    sad_valid,
    output logic [SAD_W-1:0]        sad_out,
    output logic [IDX_W-1:0]        sad_idx,
    output logic [SAD_W-1:0]        best_sad,
    output logic [IDX_W-1:0]        best_idx,
    output logic                    done
);

    localparam int TREE_W = PIXEL + $clog2(NUM_PE);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ROW_W-1:0] c_LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] c_LAST_CAND = IDX_W'(NUM_CAND - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [TREE_W-1:0] w_lvl [NUM_PE];
    logic [TREE_W-1:0] w_tree_sum;
    logic [TREE_W-1:0] r_tree_sum;
    logic              r_tree_valid;
    logic [SAD_W-1:0]  r_acc;
    logic [SAD_W-1:0]  w_acc_sum;
    logic [ROW_W-1:0]  r_row_cnt;
    logic [IDX_W-1:0]  r_cand_cnt;
    logic              w_running;
    logic              w_last_cand;

    // Pairwise reduction: stride doubles each level, partial sums land in lane 0.
    always_comb begin
        for (int k = 0; k < NUM_PE; k++) begin
            w_lvl[k] = TREE_W'(abs_in[k*PIXEL +: PIXEL]);
        end
        for (int s = 1; s < NUM_PE; s = s * 2) begin
            for (int k = 0; k + s < NUM_PE; k = k + 2 * s) begin
                w_lvl[k] = w_lvl[k] + w_lvl[k+s];
            end
        end
        w_tree_sum = w_lvl[0];
    end

    assign w_running   = (r_state == c_RUN);
    assign w_acc_sum   = r_acc + SAD_W'(r_tree_sum);
    assign w_last_cand = w_running && r_sad_valid_q() && (r_cand_cnt == c_LAST_CAND);

    function automatic logic r_sad_valid_q();
        return sad_valid;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (search_start) w_state_next = c_RUN;
            c_RUN:   if (w_last_cand) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
        if (search_start) begin
            w_state_next = c_RUN;
        end
    end

    always_comb begin
        busy = (r_state == c_RUN);
        done = (r_state == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tree_valid <= 1'b0;
            r_tree_sum   <= '0;
            r_acc        <= '0;
            r_row_cnt    <= '0;
            r_cand_cnt   <= '0;
            sad_valid    <= 1'b0;
            sad_out      <= '0;
            sad_idx      <= '0;
            best_sad     <= '1;
            best_idx     <= '0;
        end else if (search_start) begin
            // sad_out/sad_idx keep the last result; only in-flight flags drop.
            r_tree_valid <= 1'b0;
            r_acc        <= '0;
            r_row_cnt    <= '0;
            r_cand_cnt   <= '0;
            sad_valid    <= 1'b0;
            best_sad     <= '1;
            best_idx     <= '0;
        end else begin
            r_tree_valid <= w_running && abs_valid;
            if (w_running && abs_valid) begin
                r_tree_sum <= w_tree_sum;
            end

            sad_valid <= 1'b0;
            if (w_running && r_tree_valid) begin
                if (r_row_cnt == c_LAST_ROW) begin
                    sad_out   <= w_acc_sum;
                    sad_idx   <= r_cand_cnt;
                    sad_valid <= 1'b1;
                    r_acc     <= '0;
                    r_row_cnt <= '0;
                end else begin
                    r_acc     <= w_acc_sum;
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
            end

            // Strict compare keeps the earliest candidate on ties.
            if (w_running && sad_valid) begin
                if (sad_out < best_sad) begin
                    best_sad <= sad_out;
                    best_idx <= sad_idx;
                end
                r_cand_cnt <= (r_cand_cnt == c_LAST_CAND) ? '0 : r_cand_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sad_tree_min.sv
// =============================================================================
// Module      : tb_sad_tree_min
// Description : Directed self-checking bench for sad_tree_min.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_sad_tree_min;

    localparam int PIXEL  = 8;
    localparam int NUM_PE = 8;
    localparam int SAD_W  = 14;
    localparam logic [SAD_W-1:0] c_ONES = '1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    search_start = 1'b0;
    logic                    abs_valid = 1'b0;
    logic [NUM_PE*PIXEL-1:0] abs_in = '0;

    logic             busy, sad_valid, done;
    logic [SAD_W-1:0] sad_out, best_sad;
    logic [1:0]       sad_idx, best_idx;

    logic             d1_busy, d1_sad_valid, d1_done;
    logic [SAD_W-1:0] d1_sad_out, d1_best_sad;
    logic [0:0]       d1_sad_idx, d1_best_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int n_sad    = 0;
    int n_done   = 0;
    int base;
    logic [SAD_W-1:0] exp_q[$];
    logic [SAD_W-1:0] tie_sads [4] = '{14'd100, 14'd50, 14'd50, 14'd70};

    always #5 clk = ~clk;

    sad_tree_min #(.NUM_CAND(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .search_start(search_start),
        .abs_valid(abs_valid), .abs_in(abs_in), .busy(busy),
        .sad_valid(sad_valid), .sad_out(sad_out), .sad_idx(sad_idx),
        .best_sad(best_sad), .best_idx(best_idx), .done(done)
    );

    sad_tree_min #(.NUM_CAND(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .search_start(search_start),
        .abs_valid(abs_valid), .abs_in(abs_in), .busy(d1_busy),
        .sad_valid(d1_sad_valid), .sad_out(d1_sad_out), .sad_idx(d1_sad_idx),
        .best_sad(d1_best_sad), .best_idx(d1_best_idx), .done(d1_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and score any SAD the 4-candidate instance emits.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sad_valid) begin
            if (exp_q.size() == 0) begin
                check("sad_unexpected", sad_valid, 0);
            end else begin
                check("sad_out", sad_out, exp_q.pop_front());
                check("sad_idx", sad_idx, n_sad);
            end
            n_sad++;
        end
        if (done) n_done++;
    endtask

    task automatic row(input logic [7:0] lane);
        abs_valid = 1'b1;
        abs_in    = {NUM_PE{lane}};
        tick();
        abs_valid = 1'b0;
    endtask

    task automatic restart();
        exp_q.delete();
        n_sad  = 0;
        n_done = 0;
        search_start = 1'b1;
        tick();
        search_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sad_valid", sad_valid, 0);
        check("rst_done", done, 0);
        check("rst_sad_out", sad_out, 0);
        check("rst_best_sad", best_sad, c_ONES);
        check("rst_best_idx", best_idx, 0);
        rst_n = 1'b1;
        tick();

        // Single candidate on the NUM_CAND=1 instance, exact latency.
        restart();
        exp_q.push_back(14'd64);
        check("t1_busy", d1_busy, 1);
        for (int r = 0; r < 8; r++) row(8'd1);
        check("t1_sv_early", d1_sad_valid, 0);
        tick();
        check("t1_sad_valid", d1_sad_valid, 1);
        check("t1_sad_out", d1_sad_out, 64);
        check("t1_sad_idx", d1_sad_idx, 0);
        check("t1_done_early", d1_done, 0);
        tick();
        check("t1_done", d1_done, 1);
        check("t1_busy_done", d1_busy, 0);
        check("t1_best_sad", d1_best_sad, 64);
        check("t1_best_idx", d1_best_idx, 0);
        tick();
        check("t1_done_once", d1_done, 0);
        check("t1_best_hold", d1_best_sad, 64);

        // Maximum input, no wrap.
        restart();
        exp_q.push_back(14'd16320);
        for (int r = 0; r < 8; r++) row(8'd255);
        repeat (3) tick();
        check("t2_count", n_sad, 1);

        // Ties: earliest minimum wins, single done after the 4th SAD.
        restart();
        for (int c = 0; c < 4; c++) exp_q.push_back(tie_sads[c]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 8; r++) begin
                abs_valid = 1'b1;
                abs_in    = (r == 0) ? {{(NUM_PE-1)*PIXEL{1'b0}}, tie_sads[c][7:0]} : '0;
                tick();
            end
        end
        abs_valid = 1'b0;
        for (int i = 0; i < 10 && n_done == 0; i++) tick();
        check("t3_done_seen", n_done, 1);
        check("t3_sads_at_done", n_sad, 4);
        check("t3_best_sad", best_sad, 50);
        check("t3_best_idx", best_idx, 1);
        check("t3_busy", busy, 0);
        repeat (4) tick();
        check("t3_done_count", n_done, 1);
        check("t3_best_hold", best_sad, 50);

        // Bubbles versus gap-free: rows of value r+1 give 8*36 = 288.
        restart();
        exp_q.push_back(14'd288);
        exp_q.push_back(14'd288);
        for (int r = 0; r < 8; r++) begin
            row(8'(r + 1));
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (3) tick();
        check("t4_one_per_cand", n_sad, 1);
        for (int r = 0; r < 8; r++) row(8'(r + 1));
        repeat (3) tick();
        check("t4_gapfree", n_sad, 2);

        // Restart after 3 rows of candidate 2.
        restart();
        exp_q.push_back(14'd64);
        exp_q.push_back(14'd64);
        for (int r = 0; r < 16; r++) row(8'd1);
        for (int r = 0; r < 3; r++) row(8'd5);
        base = n_sad;
        check("t5_pre_count", base, 2);
        exp_q.delete();
        n_sad = 0;
        n_done = 0;
        search_start = 1'b1;
        abs_valid    = 1'b1;
        abs_in       = {NUM_PE{8'd200}};
        tick();
        search_start = 1'b0;
        abs_valid    = 1'b0;
        check("t5_busy", busy, 1);
        check("t5_best_sad", best_sad, c_ONES);
        check("t5_best_idx", best_idx, 0);
        exp_q.push_back(14'd128);
        for (int r = 0; r < 8; r++) row(8'd2);
        repeat (3) tick();
        check("t5_new_count", n_sad, 1);
        check("t5_no_done", n_done, 0);

        // Asynchronous reset mid-search.
        restart();
        for (int r = 0; r < 4; r++) row(8'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_sad_out", sad_out, 0);
        check("t6_best_sad", best_sad, c_ONES);
        check("t6_best_idx", best_idx, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 10; r++) row(8'd7);
        repeat (3) tick();
        check("t6_ignored", n_sad, 0);
        check("t6_busy_idle", busy, 0);
        check("t6_no_done", n_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
